// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader: assembles framed serial bits into a WIDTH-bit word for the byte storage register.
// Optional even-parity bit per word when SERIAL_BYTE_LOADER_PARITY_EN is defined.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_start,
  output logic [WIDTH-1:0] data_out,
  output logic             wrt,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_out_n;
  logic             wrt_n, busy_n, frame_err_n;
  logic [WIDTH-1:0] shift_base, shifted;

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  logic parity_err_q, parity_err_n;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      data_out  <= '0;
      wrt       <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      data_out  <= data_out_n;
      wrt       <= wrt_n;
      busy      <= busy_n;
      frame_err <= frame_err_n;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      parity_err_q <= parity_err_n;
`endif
    end
  end

  // A start bit begins from a clean register so stale bits never leak into a new word.
  always_comb begin
    shift_base = sin_start ? '0 : sr;
    if (MSB_FIRST != 0) shifted = {shift_base[WIDTH-2:0], sin_data};
    else                shifted = {sin_data, shift_base[WIDTH-1:1]};
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    data_out_n  = data_out;
    wrt_n       = 1'b0;
    frame_err_n = 1'b0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    parity_err_n = 1'b0;
`endif
    if (sin_valid) begin
      if (sin_start) begin
        frame_err_n = (state != IDLE);
        sr_n        = shifted;
        cnt_n       = CW'(1);
        state_n     = SHIFT;
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            sr_n  = shifted;
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
              state_n = PARITY;
`else
              data_out_n = shifted;
              wrt_n      = 1'b1;
              cnt_n      = '0;
              state_n    = IDLE;
`endif
            end
          end
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
          PARITY: begin
            if ((^sr ^ sin_data) == 1'b0) begin
              data_out_n = sr;
              wrt_n      = 1'b1;
            end else begin
              parity_err_n = 1'b1;
            end
            cnt_n   = '0;
            state_n = IDLE;
          end
`endif
          default: begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        endcase
      end
    end
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench for serial_byte_loader: LSB-first and MSB-first instances share one serial stream.
// Define SERIAL_BYTE_LOADER_PARITY_EN for both files to exercise the parity build.
module tb_serial_byte_loader;

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin_data = 1'b0;
  logic       sin_start = 1'b0;
  logic [7:0] l_data, m_data;
  logic       l_wrt, l_busy, l_fe, l_pe;
  logic       m_wrt, m_busy, m_fe, m_pe;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_wrt_cyc = 0;
  int wrt_gap = 0;
  logic [7:0] exp_lsb[$];
  logic [7:0] exp_msb[$];

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .data_out(l_data), .wrt(l_wrt), .busy(l_busy), .frame_err(l_fe), .parity_err(l_pe)
  );

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_data(sin_data), .sin_start(sin_start),
    .data_out(m_data), .wrt(m_wrt), .busy(m_busy), .frame_err(m_fe), .parity_err(m_pe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every wrt and checks pulse exclusivity.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      if (l_wrt) begin
        vectors++;
        if (exp_lsb.size() == 0) begin
          miscompares++;
          $display("FAIL lsb_unexpected_wrt: got data_out=%h, expected no word", l_data);
        end else begin
          e = exp_lsb.pop_front();
          if (l_data !== e) begin
            miscompares++;
            $display("FAIL lsb_word: got %h, expected %h", l_data, e);
          end
        end
        wrt_gap = cyc - last_wrt_cyc;
        last_wrt_cyc = cyc;
      end
      if (m_wrt) begin
        vectors++;
        if (exp_msb.size() == 0) begin
          miscompares++;
          $display("FAIL msb_unexpected_wrt: got data_out=%h, expected no word", m_data);
        end else begin
          e = exp_msb.pop_front();
          if (m_data !== e) begin
            miscompares++;
            $display("FAIL msb_word: got %h, expected %h", m_data, e);
          end
        end
      end
      if (l_wrt || l_fe || l_pe) begin
        vectors++;
        if ((int'(l_wrt) + int'(l_fe) + int'(l_pe)) != 1) begin
          miscompares++;
          $display("FAIL pulse_exclusive: got wrt=%b frame_err=%b parity_err=%b, expected one-hot", l_wrt, l_fe, l_pe);
        end
      end
    end
  end

  task automatic idle(input int n);
    sin_valid = 1'b0;
    sin_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sin_valid = 1'b1;
      sin_data  = w[i];
      sin_start = (i == 0);
      @(negedge clk);
      vectors++;
      if (l_busy !== 1'b1 || l_wrt !== 1'b0) begin
        miscompares++;
        $display("FAIL partial_bit%0d: got busy=%b wrt=%b, expected busy=1 wrt=0", i, l_busy, l_wrt);
      end
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  // Sends w (bit 0 first) plus a parity bit in the parity build; leaves sin_valid high on the last bit.
  task automatic send_word(input logic [7:0] w, input int maxgap, input bit expect_fe, input bit bad_par);
    logic [8:0] bits;
    int gap;
    bits = {(^w) ^ bad_par, w};
    if (!bad_par) begin
      exp_lsb.push_back(w);
      exp_msb.push_back(rev8(w));
    end
    for (int i = 0; i < NB; i++) begin
      sin_valid = 1'b1;
      sin_data  = bits[i];
      sin_start = (i == 0);
      @(negedge clk);
      if (i == 0) begin
        vectors++;
        if (l_fe !== expect_fe || m_fe !== expect_fe) begin
          miscompares++;
          $display("FAIL frame_err_on_start: got lsb=%b msb=%b, expected %b", l_fe, m_fe, expect_fe);
        end
      end
      if (i < NB - 1) begin
        vectors++;
        if (l_busy !== 1'b1 || l_wrt !== 1'b0 || m_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL mid_word_bit%0d: got busy=%b wrt=%b, expected busy=1 wrt=0", i, l_busy, l_wrt);
        end
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          vectors++;
          if (l_busy !== 1'b1 || l_wrt !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_hold: got busy=%b wrt=%b, expected busy=1 wrt=0", l_busy, l_wrt);
          end
        end
      end else begin
        vectors++;
        if (l_wrt !== !bad_par || m_wrt !== !bad_par || l_pe !== bad_par || l_busy !== 1'b0) begin
          miscompares++;
          $display("FAIL word_end: got wrt=%b parity_err=%b busy=%b, expected wrt=%b parity_err=%b busy=0",
                   l_wrt, l_pe, l_busy, !bad_par, bad_par);
        end
      end
    end
  endtask

  task automatic test_reset;
    send_word(8'h33, 0, 1'b0, 1'b0);
    idle(2);
    send_partial(8'h07, 3);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (l_data !== 8'h00 || m_data !== 8'h00 || l_wrt !== 1'b0 || l_busy !== 1'b0 ||
        l_fe !== 1'b0 || l_pe !== 1'b0 || m_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got data=%h/%h wrt=%b busy=%b fe=%b pe=%b, expected all 0",
               l_data, m_data, l_wrt, l_busy, l_fe, l_pe);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    send_word(8'h5A, 0, 1'b0, 1'b0);
    idle(1);
    vectors++;
    if (l_wrt !== 1'b0 || l_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL wrt_one_cycle: got wrt=%b data=%h, expected wrt=0 data=5a", l_wrt, l_data);
    end
  endtask

  task automatic test_lsb_basic;
    idle(2);
    send_word(8'hA5, 3, 1'b0, 1'b0);
    idle(2);
  endtask

  task automatic test_msb;
    send_word(8'hA5, 2, 1'b0, 1'b0);
    idle(1);
    send_word(8'h03, 1, 1'b0, 1'b0);
    idle(1);
    vectors++;
    if (m_data !== 8'hC0 || l_data !== 8'h03) begin
      miscompares++;
      $display("FAIL msb_hold: got msb=%h lsb=%h, expected c0/03", m_data, l_data);
    end
  endtask

  task automatic test_reframe;
    send_partial(8'hFF, 4);
    send_word(8'h3C, 1, 1'b1, 1'b0);
    idle(2);
    vectors++;
    if (l_data !== 8'h3C || l_fe !== 1'b0) begin
      miscompares++;
      $display("FAIL reframe_result: got data=%h fe=%b, expected 3c fe=0", l_data, l_fe);
    end
  endtask

  task automatic test_back_to_back;
    idle(1);
    send_word(8'h01, 0, 1'b0, 1'b0);
    send_word(8'hFF, 0, 1'b0, 1'b0);
    idle(1);
    vectors++;
    if (wrt_gap !== NB) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles, expected %0d", wrt_gap, NB);
    end
  endtask

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  task automatic test_parity;
    idle(1);
    send_word(8'hA5, 0, 1'b0, 1'b0);
    idle(1);
    send_word(8'h0F, 1, 1'b0, 1'b1);
    idle(2);
    vectors++;
    if (l_data !== 8'hA5 || l_pe !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_hold: got data=%h pe=%b, expected a5 pe=0", l_data, l_pe);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    vectors++;
    if (l_data !== 8'h00 || l_wrt !== 1'b0 || l_busy !== 1'b0 || l_fe !== 1'b0 || l_pe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got data=%h wrt=%b busy=%b fe=%b pe=%b, expected all 0",
               l_data, l_wrt, l_busy, l_fe, l_pe);
    end
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_lsb_basic();
    test_msb();
    test_reframe();
    test_back_to_back();
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    test_parity();
`endif
    idle(3);
    vectors++;
    if (exp_lsb.size() != 0 || exp_msb.size() != 0) begin
      miscompares++;
      $display("FAIL words_missing: got %0d/%0d words outstanding, expected 0", exp_lsb.size(), exp_msb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

Serial-to-parallel front end for the byte storage register. Assembles a framed serial bit stream into a WIDTH-bit word. Presents the completed word on `data_out` with a one-cycle `wrt` strobe, so it drives the storage register's `data_in`/`wrt` pins directly. Detects re-framing errors and, optionally, parity errors.

## Interface
- `WIDTH`, 8: data bits per word; legal range ≥ 2.
- `MSB_FIRST`, 0: 0 = first received bit lands in `data_out[0]`; 1 = first bit lands in `data_out[WIDTH-1]`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low; asserting it (0) clears all state immediately.
- `sin_valid` input 1: the serial bit on `sin_data` is valid this cycle.
- `sin_data` input 1: serial data bit.
- `sin_start` input 1: marks the current valid bit as the first bit of a word; ignored when `sin_valid`=0.
- `data_out` output WIDTH: last successfully received word, held until the next successful word.
- `wrt` output 1: one-cycle pulse; `data_out` carries a new word this cycle.
- `busy` output 1: a word is partially received (state ≠ IDLE).
- `frame_err` output 1: one-cycle pulse; a partial word was abandoned by a new `sin_start`.
- `parity_err` output 1: one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.

## Operation
- Internal state: WIDTH-bit shift register, bit counter of width `$clog2(WIDTH+1)`, FSM {IDLE, SHIFT, PARITY}.
- Reset values: `data_out`=0, `wrt`=0, `busy`=0, `frame_err`=0, `parity_err`=0, FSM=IDLE, counter=0.
- IDLE:
  - `sin_valid`&`sin_start`: store the bit as bit 1 of the word, counter=1, go to SHIFT.
  - `sin_valid` without `sin_start`: the bit is discarded and no output changes.
- SHIFT, `sin_valid`&`sin_start`: pulse `frame_err` and discard the partial word. The current bit becomes bit 1 of a new word, counter=1, and the state stays SHIFT.
- SHIFT, `sin_valid`&!`sin_start`: store the bit and increment the counter.
  - When the counter reaches WIDTH without parity: load `data_out`, pulse `wrt`, go to IDLE.
  - When the counter reaches WIDTH with parity: go to PARITY.
- PARITY, `sin_valid`: the bit is the even-parity bit, so XOR of the WIDTH data bits and the parity bit must be 0.
  - Match: load `data_out`, pulse `wrt`, go to IDLE.
  - Mismatch: pulse `parity_err`, leave `data_out` unchanged, go to IDLE.
  - If `sin_start`=1 in this state: treat it as a re-frame, exactly as in SHIFT.
- `sin_valid`=0 in any state: hold all state. Gaps of any length are legal.
- Bit placement with `MSB_FIRST`=0: shift right, new bit enters at [WIDTH-1]. After WIDTH bits, the first bit sits at [0].
- Bit placement with `MSB_FIRST`=1: shift left, new bit enters at [0].
- `rst` asserted mid-word: the partial word is lost and all outputs return to their reset values, including `data_out`.
- `wrt`, `frame_err` and `parity_err` are mutually exclusive in any cycle.

## Timing
- All outputs are registered.
- `wrt` and `data_out` update in the cycle after the rising edge that samples the last data bit, or the parity bit when parity is enabled. This is a latency of 1 cycle.
- `frame_err` and `parity_err` assert the cycle after the offending bit is sampled.
- `busy` rises the cycle after the start bit is sampled. It falls in the same cycle `wrt`, `parity_err` or the terminating transition appears.
- Back-to-back words are allowed at full rate. A start bit sampled in the cycle `wrt` is high is accepted, so there are no dead cycles between words.

## Configuration
- `SERIAL_BYTE_LOADER_PARITY_EN` defined:
  - The PARITY state exists.
  - Each word is WIDTH data bits followed by one even-parity bit.
  - `parity_err` is live.
- Macro undefined:
  - No PARITY state.
  - A word completes on its WIDTH-th bit.
  - `parity_err` is tied to 0.

## Test plan
- Reset: drive `rst`=0 mid-stream with 3 bits received. The outputs go to 0 asynchronously. Then release `rst`, send a full word 0x5A, and expect `data_out`=0x5A, `wrt`=1 for exactly 1 cycle.
- LSB-first basic: with `MSB_FIRST`=0, send bits 1,0,1,0,0,1,0,1 with start on the first bit and `sin_valid` gaps of 0–3 cycles between bits. Expect `data_out`=0xA5 and a single `wrt` pulse 1 cycle after the last bit; `busy`=1 throughout the word.
- MSB-first: with `MSB_FIRST`=1, send the same bit sequence. Expect `data_out`=0xA5 (the sequence is a palindrome); then send 1,1,0,0,0,0,0,0 and expect 0xC0.
- Re-frame: send 4 bits of a word, then `sin_start` with new word 0x3C. Expect a 1-cycle `frame_err`, no `wrt` for the aborted word, then `data_out`=0x3C with `wrt`.
- Back-to-back: send 0x01 then 0xFF with `sin_valid` held high continuously (16 cycles). Expect two `wrt` pulses exactly 8 cycles apart, with `data_out`=0x01 then 0xFF.
- Parity (macro defined):
  - Send 0xA5 followed by parity 0: expect `wrt`, `data_out`=0xA5.
  - Then send 0x0F followed by parity 1: expect `parity_err` pulse, no `wrt`, `data_out` still 0xA5.
